// File: rtl/calc_pkg.sv
// ---------------------------------------------------------------------------
// calc_pkg
// Shared definitions for the calc_int multiply scheduler:
//   state_e      - scheduler FSM states (IDLE / WAIT / RESP)
//   FP_INF       - IEEE-754 single +infinity
//   FP_EXP_MAX   - all-ones single-precision exponent (Inf/NaN)
//   MUL_LAT_DEF  - default settle latency of the iterative multiplier core
//   idx_onehot() - requester index to one-hot response vector
// ---------------------------------------------------------------------------
package calc_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam logic [31:0] FP_INF      = 32'h7F80_0000;
   localparam logic [7:0]  FP_EXP_MAX  = 8'hFF;
   localparam int          MUL_LAT_DEF = 28;

   function automatic logic [1:0] idx_onehot(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/fmul_sched_if.sv
// ---------------------------------------------------------------------------
// fmul_sched_if
// Bundles the requester handshakes and the multiplier-core operand/result
// bus of fmul_sched.
//   slave  modport : the scheduler itself
//   master modport : the surrounding datapath (requesters + core)
// Signals:
//   req_valid/req_ready [1:0]   request handshake, one bit per requester
//   req_a0/req_b0/req_a1/req_b1 operands (IEEE-754 single)
//   rsp_valid/rsp_ready [1:0]   response handshake, one-hot valid
//   rsp_s, rsp_ovf              product and overflow flag
//   mul_a, mul_b                operands held on the core
//   mul_s, mul_ovf              core result
//   busy                        scheduler not idle
// ---------------------------------------------------------------------------
interface fmul_sched_if;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [31:0] req_a0;
   logic [31:0] req_b0;
   logic [31:0] req_a1;
   logic [31:0] req_b1;
   logic [1:0]  rsp_valid;
   logic [1:0]  rsp_ready;
   logic [31:0] rsp_s;
   logic        rsp_ovf;
   logic [31:0] mul_a;
   logic [31:0] mul_b;
   logic [31:0] mul_s;
   logic        mul_ovf;
   logic        busy;

   modport slave (
      input  req_valid, req_a0, req_b0, req_a1, req_b1, rsp_ready, mul_s, mul_ovf,
      output req_ready, rsp_valid, rsp_s, rsp_ovf, mul_a, mul_b, busy
   );

   modport master (
      output req_valid, req_a0, req_b0, req_a1, req_b1, rsp_ready, mul_s, mul_ovf,
      input  req_ready, rsp_valid, rsp_s, rsp_ovf, mul_a, mul_b, busy
   );
endinterface

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Purely combinational 2-way round-robin arbiter.
//   req_i   [1:0] request vector
//   last_i        index granted most recently
//   grant_o [1:0] one-hot grant (all zero when no request)
// With both requesting, the index that was not served last wins; a lone
// requester always wins.
// ---------------------------------------------------------------------------
module rr_arb2 (
   input  logic [1:0] req_i,
   input  logic       last_i,
   output logic [1:0] grant_o
);

   assign grant_o[0] = req_i[0] & (~req_i[1] |  last_i);
   assign grant_o[1] = req_i[1] & (~req_i[0] | ~last_i);

endmodule

// File: rtl/fmul_sched.sv
// ---------------------------------------------------------------------------
// fmul_sched
// Shares one iterative single-precision multiplier core between two
// requesters. A round-robin winner's operands are latched onto the core and
// held for MUL_LAT cycles, the core result is captured and then returned to
// that requester over a valid/ready handshake.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous, active-high reset
//   bus  - fmul_sched_if.slave (requests, responses, core bus, busy)
// Parameter:
//   MUL_LAT - core settle latency in cycles, 2..255
// Build option:
//   FMUL_SCHED_FASTPATH_EN - Inf/NaN or zero operands bypass the core and
//                            respond in the cycle after accept.
// ---------------------------------------------------------------------------
module fmul_sched
   import calc_pkg::*;
#(
   parameter int MUL_LAT = MUL_LAT_DEF
) (
   input  logic         clk,
   input  logic         rst,
   fmul_sched_if.slave  bus
);

   localparam logic [7:0] LAST_CNT = 8'(MUL_LAT - 1);

   state_e      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        last_q, last_d;
   logic        id_q, id_d;
   logic [31:0] mul_a_q, mul_a_d;
   logic [31:0] mul_b_q, mul_b_d;
   logic [31:0] rsp_s_q, rsp_s_d;
   logic        rsp_ovf_q, rsp_ovf_d;
   logic [1:0]  rsp_valid_q, rsp_valid_d;
   logic        busy_q, busy_d;

   logic [1:0]  grant;
   logic [1:0]  req_ready;
   logic        accept;
   logic        gidx;
   logic [31:0] op_a, op_b;

   rr_arb2 u_arb (
      .req_i   (bus.req_valid),
      .last_i  (last_q),
      .grant_o (grant)
   );

   // Ready is combinational so a request can be taken in the same cycle it
   // first appears.
   assign req_ready = (state_q == IDLE && !rst) ? grant : 2'b00;
   assign accept    = |(bus.req_valid & req_ready);
   assign gidx      = grant[1];
   assign op_a      = gidx ? bus.req_a1 : bus.req_a0;
   assign op_b      = gidx ? bus.req_b1 : bus.req_b0;

   always_comb begin
      // NOTE: every next-state signal gets its hold value first; a path that
      // leaves one unassigned would infer a latch.
      state_d     = state_q;
      cnt_d       = cnt_q;
      last_d      = last_q;
      id_d        = id_q;
      mul_a_d     = mul_a_q;
      mul_b_d     = mul_b_q;
      rsp_s_d     = rsp_s_q;
      rsp_ovf_d   = rsp_ovf_q;
      rsp_valid_d = rsp_valid_q;

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               mul_a_d = op_a;
               mul_b_d = op_b;
               id_d    = gidx;
               last_d  = gidx;
               cnt_d   = '0;
               state_d = WAIT;
`ifdef FMUL_SCHED_FASTPATH_EN
               // Special operands answer without waiting on the core; the
               // core operands are still updated so its bus stays coherent.
               if (op_a[30:23] == FP_EXP_MAX || op_b[30:23] == FP_EXP_MAX) begin
                  rsp_s_d     = FP_INF;
                  rsp_ovf_d   = 1'b1;
                  rsp_valid_d = idx_onehot(gidx);
                  state_d     = RESP;
               end else if (op_a == '0 || op_b == '0) begin
                  rsp_s_d     = '0;
                  rsp_ovf_d   = 1'b0;
                  rsp_valid_d = idx_onehot(gidx);
                  state_d     = RESP;
               end
`endif
            end
         end
         WAIT: begin
            // Exit at MUL_LAT-1 keeps the 8-bit counter from ever wrapping.
            if (cnt_q == LAST_CNT) begin
               rsp_s_d     = bus.mul_s;
               rsp_ovf_d   = bus.mul_ovf;
               rsp_valid_d = idx_onehot(id_q);
               state_d     = RESP;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         RESP: begin
            // Only the served requester's ready matters.
            if (bus.rsp_ready[id_q]) begin
               rsp_valid_d = 2'b00;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   // NOTE: state updates use non-blocking assignments so every register
   // samples the pre-edge values of the others.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the operand and result registers are reset too, not just the
         // control state, because their reset values are visible outputs.
         state_q     <= IDLE;
         cnt_q       <= '0;
         last_q      <= 1'b1;
         id_q        <= 1'b0;
         mul_a_q     <= '0;
         mul_b_q     <= '0;
         rsp_s_q     <= '0;
         rsp_ovf_q   <= 1'b0;
         rsp_valid_q <= 2'b00;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         last_q      <= last_d;
         id_q        <= id_d;
         mul_a_q     <= mul_a_d;
         mul_b_q     <= mul_b_d;
         rsp_s_q     <= rsp_s_d;
         rsp_ovf_q   <= rsp_ovf_d;
         rsp_valid_q <= rsp_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.req_ready = req_ready;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_s     = rsp_s_q;
   assign bus.rsp_ovf   = rsp_ovf_q;
   assign bus.mul_a     = mul_a_q;
   assign bus.mul_b     = mul_b_q;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_fmul_sched.sv
// ---------------------------------------------------------------------------
// tb_fmul_sched
// Directed bench for fmul_sched with a behavioural multiplier core that only
// produces a valid product after its operands have been stable MUL_LAT cycles.
// Honors FMUL_SCHED_FASTPATH_EN for the expected fast-path latency.
// ---------------------------------------------------------------------------
module tb_fmul_sched;
   import calc_pkg::*;

   localparam int LAT = 28;
`ifdef FMUL_SCHED_FASTPATH_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fmul_sched_if intf ();

   fmul_sched #(.MUL_LAT(LAT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (intf)
   );

   // ---------------- behavioural multiplier core ----------------
   function automatic logic [32:0] fmul_ref(input logic [31:0] a, input logic [31:0] b);
      logic        s;
      int          ea, eb, e;
      logic [47:0] m;
      logic [22:0] frac;
      s  = a[31] ^ b[31];
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      if (ea == 255 || eb == 255) return {1'b1, s, 8'hFF, 23'd0};
      if (a[30:0] == 31'd0 || b[30:0] == 31'd0) return {1'b0, s, 31'd0};
      m = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
      e = ea + eb - 127;
      if (m[47]) begin
         e    = e + 1;
         frac = m[46:24];
      end else begin
         frac = m[45:23];
      end
      if (e >= 255) return {1'b1, s, 8'hFF, 23'd0};
      if (e <= 0)   return {1'b0, s, 31'd0};
      return {1'b0, s, e[7:0], frac};
   endfunction

   logic [63:0] prev_ops = '0;
   int          stable   = 0;
   logic [32:0] core_res;

   always @(posedge clk) begin
      if ({intf.mul_a, intf.mul_b} != prev_ops) stable <= 1;
      else if (stable < 1000)                   stable <= stable + 1;
      prev_ops <= {intf.mul_a, intf.mul_b};
   end

   assign core_res     = fmul_ref(intf.mul_a, intf.mul_b);
   assign intf.mul_s   = (stable >= LAT - 1) ? core_res[31:0] : 32'hDEAD_BEEF;
   assign intf.mul_ovf = (stable >= LAT - 1) ? core_res[32]   : 1'b1;

   // ---------------- checking helpers ----------------
   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Call at a negedge; returns at the negedge of the cycle after accept.
   task automatic issue(input int who, input logic [31:0] a, input logic [31:0] b, output bit ok);
      if (who == 0) begin
         intf.req_a0 = a;
         intf.req_b0 = b;
      end else begin
         intf.req_a1 = a;
         intf.req_b1 = b;
      end
      intf.req_valid[who] = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         #1;
         if (intf.req_ready[who]) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      @(posedge clk);
      @(negedge clk);
      intf.req_valid[who] = 1'b0;
   endtask

   // Counts cycles from cycle T+1 until rsp_valid rises.
   task automatic wait_rsp(output int lat);
      lat = 1;
      while (intf.rsp_valid == 2'b00 && lat < 400) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic ack(input int who);
      intf.rsp_ready[who] = 1'b1;
      @(negedge clk);
      intf.rsp_ready = 2'b00;
   endtask

   typedef struct {
      int          who;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_s;
      logic        exp_ovf;
      bit          fast;
   } vec_t;

   vec_t vecs[6];

   initial begin
      bit          ok;
      int          lat;
      int          n_acc, n_rsp, last_c;
      bit          stable_ok;
      logic [1:0]  exp_order[4];

      vecs[0] = '{0, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 1'b0, 1'b0};
      vecs[1] = '{1, 32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 1'b1, 1'b0};
      vecs[2] = '{0, 32'h0000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 1'b1};
      vecs[3] = '{1, 32'h3FC0_0000, 32'hC000_0000, 32'hC040_0000, 1'b0, 1'b0};
      vecs[4] = '{0, 32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000, 1'b1, 1'b1};
      vecs[5] = '{1, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 1'b0};
      exp_order[0] = 2'b01;
      exp_order[1] = 2'b10;
      exp_order[2] = 2'b01;
      exp_order[3] = 2'b10;

      intf.req_valid = 2'b11;
      intf.req_a0    = 32'h4000_0000;
      intf.req_b0    = 32'h4040_0000;
      intf.req_a1    = 32'h3FC0_0000;
      intf.req_b1    = 32'hC000_0000;
      intf.rsp_ready = 2'b00;

      // ---- reset values ----
      repeat (3) @(negedge clk);
      #1;
      check("rst_req_ready", intf.req_ready, 2'b00);
      check("rst_rsp_valid", intf.rsp_valid, 2'b00);
      check("rst_rsp_s",     intf.rsp_s,     32'h0);
      check("rst_rsp_ovf",   intf.rsp_ovf,   1'b0);
      check("rst_mul_a",     intf.mul_a,     32'h0);
      check("rst_mul_b",     intf.mul_b,     32'h0);
      check("rst_busy",      intf.busy,      1'b0);
      @(negedge clk);
      rst = 1'b0;

      // ---- both valid: grants alternate 0,1,0,1 at MUL_LAT+2 spacing ----
      intf.rsp_ready = 2'b11;
      n_acc  = 0;
      n_rsp  = 0;
      last_c = 0;
      for (int c = 0; c < 600 && n_rsp < 4; c++) begin
         #1;
         if (intf.req_ready != 2'b00 && n_acc < 4) begin
            check("rr_grant", intf.req_ready, exp_order[n_acc]);
            if (n_acc > 0) check("rr_interval", c - last_c, LAT + 2);
            last_c = c;
            n_acc++;
         end
         if (intf.rsp_valid != 2'b00) begin
            check("rr_rsp_valid", intf.rsp_valid, exp_order[n_rsp]);
            check("rr_rsp_s", intf.rsp_s,
                  (exp_order[n_rsp] == 2'b01) ? 32'h40C0_0000 : 32'hC040_0000);
            n_rsp++;
         end
         @(negedge clk);
      end
      check("rr_done", n_rsp, 4);
      intf.req_valid = 2'b00;
      intf.rsp_ready = 2'b00;
      @(negedge clk);

      // ---- directed vector table ----
      foreach (vecs[i]) begin
         issue(vecs[i].who, vecs[i].a, vecs[i].b, ok);
         check("v_accept", ok, 1'b1);
         wait_rsp(lat);
         check("v_latency", lat, (FAST && vecs[i].fast) ? 1 : LAT + 1);
         check("v_rsp_valid", intf.rsp_valid, idx_onehot(vecs[i].who[0]));
         check("v_rsp_s", intf.rsp_s, vecs[i].exp_s);
         check("v_rsp_ovf", intf.rsp_ovf, vecs[i].exp_ovf);
         ack(vecs[i].who);
         #1;
         check("v_rsp_clear", intf.rsp_valid, 2'b00);
         @(negedge clk);
      end

      // ---- back-pressure in RESP, other requester waiting ----
      issue(0, 32'h4000_0000, 32'h4040_0000, ok);
      intf.req_a1 = 32'h3FC0_0000;
      intf.req_b1 = 32'hC000_0000;
      intf.req_valid[1] = 1'b1;
      #1;
      check("hold_busy", intf.busy, 1'b1);
      check("hold_wait_ready", intf.req_ready, 2'b00);
      wait_rsp(lat);
      check("hold_latency", lat, LAT + 1);
      intf.rsp_ready = 2'b10;   // wrong requester's ready must be ignored
      stable_ok = 1'b1;
      for (int c = 0; c < 10; c++) begin
         #1;
         if (intf.rsp_valid != 2'b01 || intf.rsp_s != 32'h40C0_0000 || intf.req_ready != 2'b00)
            stable_ok = 1'b0;
         @(negedge clk);
      end
      check("hold_stable", stable_ok, 1'b1);
      intf.rsp_ready = 2'b01;
      @(negedge clk);
      intf.rsp_ready = 2'b00;
      #1;
      check("hold_next_ready", intf.req_ready, 2'b10);
      @(posedge clk);
      @(negedge clk);
      intf.req_valid[1] = 1'b0;
      wait_rsp(lat);
      check("hold_r1_valid", intf.rsp_valid, 2'b10);
      check("hold_r1_s", intf.rsp_s, 32'hC040_0000);
      ack(1);
      @(negedge clk);

      // ---- reset at cnt==5 in WAIT ----
      issue(0, 32'h3F80_0000, 32'h3F80_0000, ok);   // last becomes 0
      repeat (5) @(negedge clk);                     // now cnt==5
      intf.req_a0    = 32'h4000_0000;
      intf.req_b0    = 32'h4040_0000;
      intf.req_valid = 2'b11;
      rst = 1'b1;
      #1;
      check("mid_rst_ready", intf.req_ready, 2'b00);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("mid_rst_rsp_valid", intf.rsp_valid, 2'b00);
      check("mid_rst_busy", intf.busy, 1'b0);
      check("mid_rst_grant", intf.req_ready, 2'b01);
      @(posedge clk);
      @(negedge clk);
      intf.req_valid = 2'b00;
      wait_rsp(lat);
      check("mid_rst_latency", lat, LAT + 1);
      check("mid_rst_s", intf.rsp_s, 32'h40C0_0000);
      ack(0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
